// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// Requests are granted round-robin and executed one at a time. The ALU is driven
// from registers for a single EXEC cycle. The result and flags are returned over a
// registered valid/ready response channel.
// Optional feature macro: ALU_ARB_OPCHECK_EN. When it is defined, opcode 7 is
// answered directly with an error response (rsp_err) and is never sent to the ALU.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [2:0]       req_op0,
    input  logic [2:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [NREQ-1:0]  rsp_valid,
    input  logic [NREQ-1:0]  rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_negative,
`ifdef ALU_ARB_OPCHECK_EN
    output logic             rsp_err,
`endif
    output logic [2:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_negative
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic              ptr;
    logic              owner;
    logic              grant;
    logic [2:0]        sel_op;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic              illegal_op;

    // Round-robin grant: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        grant     = 1'b0;
        req_ready = '0;
        if (state == IDLE && !rst && req_valid != '0) begin
            if (req_valid[0] && req_valid[1]) begin
                grant = ptr;
            end else begin
                grant = req_valid[1];
            end
            req_ready = grant ? 2'b10 : 2'b01;
        end
    end

    // Operation of whichever requester holds the grant.
    always_comb begin
        sel_op = grant ? req_op1 : req_op0;
        sel_a  = grant ? req_a1  : req_a0;
        sel_b  = grant ? req_b1  : req_b0;
    end

`ifdef ALU_ARB_OPCHECK_EN
    assign illegal_op = (sel_op == 3'd7);
`else
    assign illegal_op = 1'b0;
`endif

    // Sequencer. The ALU drive registers only change when a legal operation is
    // accepted, so the ALU sees stable inputs and never sees opcode 7 in checked builds.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= 1'b0;
            owner        <= 1'b0;
            rsp_valid    <= '0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_negative <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            rsp_err      <= 1'b0;
`endif
            alu_opcode   <= 3'd0;
            alu_in1      <= '0;
            alu_in2      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ready != '0) begin
                        owner <= grant;
                        if (illegal_op) begin
                            rsp_valid    <= {grant, !grant};
                            rsp_result   <= '0;
                            rsp_zero     <= 1'b1;
                            rsp_negative <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
                            rsp_err      <= 1'b1;
`endif
                            state        <= RESP;
                        end else begin
                            alu_opcode <= sel_op;
                            alu_in1    <= sel_a;
                            alu_in2    <= sel_b;
                            state      <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    rsp_result   <= alu_result;
                    rsp_zero     <= alu_zero;
                    rsp_negative <= alu_negative;
`ifdef ALU_ARB_OPCHECK_EN
                    rsp_err      <= 1'b0;
`endif
                    rsp_valid    <= {owner, !owner};
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        ptr       <= !owner;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench for alu_share_arbiter with a response scoreboard.
// It also checks the ALU_ARB_OPCHECK_EN behaviour when that macro is defined.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2:0]       req_op0, req_op1;
    logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero, rsp_negative;
`ifdef ALU_ARB_OPCHECK_EN
    logic             rsp_err;
`endif
    logic [2:0]       alu_opcode;
    logic [WIDTH-1:0] alu_in1, alu_in2, alu_result;
    logic             alu_zero, alu_negative;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             neg;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    logic saw_op7      = 1'b0;

    alu_share_arbiter #(.WIDTH(WIDTH), .NREQ(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op0      (req_op0),
        .req_op1      (req_op1),
        .req_a0       (req_a0),
        .req_b0       (req_b0),
        .req_a1       (req_a1),
        .req_b1       (req_b1),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_negative (rsp_negative),
`ifdef ALU_ARB_OPCHECK_EN
        .rsp_err      (rsp_err),
`endif
        .alu_opcode   (alu_opcode),
        .alu_in1      (alu_in1),
        .alu_in2      (alu_in2),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative)
    );

    // Behavioural ALU that the arbiter shares.
    always_comb begin
        case (alu_opcode)
            3'd0:    alu_result = alu_in1 + alu_in2;
            3'd1:    alu_result = alu_in1 - alu_in2;
            3'd2:    alu_result = alu_in1 & alu_in2;
            3'd3:    alu_result = alu_in1 | alu_in2;
            3'd4:    alu_result = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
            3'd5:    alu_result = {31'd0, alu_in1 < alu_in2};
            3'd6:    alu_result = alu_in1 ^ alu_in2;
            default: alu_result = '0;
        endcase
        alu_zero     = (alu_result == '0);
        alu_negative = alu_result[WIDTH-1];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        repeat (5000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Records whether the ALU was ever driven with opcode 7.
    always @(negedge clk) begin
        if (alu_opcode == 3'd7) saw_op7 <= 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every completed response handshake is checked against the queue.
    always @(negedge clk) begin
        if (!rst && (rsp_valid & rsp_ready) != 2'b00) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("rsp_owner",  {30'd0, rsp_valid}, e.id ? 32'd2 : 32'd1);
                checkOutput("rsp_result", rsp_result, e.result);
                checkOutput("rsp_zero",   {31'd0, rsp_zero}, {31'd0, e.zero});
                checkOutput("rsp_neg",    {31'd0, rsp_negative}, {31'd0, e.neg});
`ifdef ALU_ARB_OPCHECK_EN
                checkOutput("rsp_err",    {31'd0, rsp_err}, {31'd0, e.err});
`endif
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid,
                                 input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1);
        req_valid = valid;
        req_op0   = op0;
        req_a0    = a0;
        req_b0    = b0;
        req_op1   = op1;
        req_a1    = a1;
        req_b1    = b1;
    endtask

    task automatic pushExpected(input logic id, input logic [31:0] result,
                                input logic zero, input logic neg, input logic err);
        exp_t e;
        e.id = id; e.result = result; e.zero = zero; e.neg = neg; e.err = err;
        sb.push_back(e);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_rsp_valid"},  {30'd0, rsp_valid}, 32'd0);
        checkOutput({tag, "_rsp_result"}, rsp_result, 32'd0);
        checkOutput({tag, "_rsp_zero"},   {31'd0, rsp_zero}, 32'd0);
        checkOutput({tag, "_rsp_neg"},    {31'd0, rsp_negative}, 32'd0);
        checkOutput({tag, "_alu_opcode"}, {29'd0, alu_opcode}, 32'd0);
        checkOutput({tag, "_alu_in1"},    alu_in1, 32'd0);
        checkOutput({tag, "_alu_in2"},    alu_in2, 32'd0);
`ifdef ALU_ARB_OPCHECK_EN
        checkOutput({tag, "_rsp_err"},    {31'd0, rsp_err}, 32'd0);
`endif
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        rsp_ready = 2'b00;
        applyStimulus(2'b01, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0);

        // Reset: nothing is granted while rst is held, outputs are at reset values.
        step(2);
        checkOutput("reset_req_ready", {30'd0, req_ready}, 32'd0);
        checkResetState("reset");
        req_valid = 2'b00;
        rst       = 1'b0;
        step(1);

        // Requester 0 Add 5+7, response two cycles after accept.
        applyStimulus(2'b01, 3'd0, 32'd5, 32'd7, 3'd0, 32'd0, 32'd0);
        #1;
        checkOutput("add_req_ready", {30'd0, req_ready}, 32'd1);
        pushExpected(1'b0, 32'd12, 1'b0, 1'b0, 1'b0);
        step(1);
        req_valid = 2'b00;
        checkOutput("add_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        checkOutput("add_exec_alu_in1", alu_in1, 32'd5);
        checkOutput("add_exec_alu_in2", alu_in2, 32'd7);
        checkOutput("add_exec_req_ready", {30'd0, req_ready}, 32'd0);
        step(1);
        checkOutput("add_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        rsp_ready = 2'b01;
        step(1);
        rsp_ready = 2'b00;
        checkOutput("add_after_hs_valid", {30'd0, rsp_valid}, 32'd0);

        // Requester 1 Sub 3-3 with a stalled response that must hold stable.
        applyStimulus(2'b10, 3'd0, 32'd0, 32'd0, 3'd1, 32'd3, 32'd3);
        pushExpected(1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1);
        req_valid = 2'b00;
        step(1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("sub_hold_valid",  {30'd0, rsp_valid}, 32'd2);
            checkOutput("sub_hold_result", rsp_result, 32'd0);
            checkOutput("sub_hold_zero",   {31'd0, rsp_zero}, 32'd1);
            step(1);
        end
        rsp_ready = 2'b10;
        step(1);
        rsp_ready = 2'b00;

        // Both requesters continuously valid after reset: grant order 0,1,0,1.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        applyStimulus(2'b11, 3'd4, 32'hFFFF_FFFF, 32'd1, 3'd5, 32'hFFFF_FFFF, 32'd1);
        rsp_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            pushExpected(1'b0, 32'd1, 1'b0, 1'b0, 1'b0);
            pushExpected(1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
        end
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            step(1);
            n++;
        end
        checkOutput("rr_cycles_for_4_ops", n, 32'd12);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        step(1);

        // rsp_ready from the non-owner is ignored, and no request is taken in RESP.
        applyStimulus(2'b01, 3'd2, 32'h0000_FF00, 32'h0000_0FF0, 3'd0, 32'd0, 32'd0);
        pushExpected(1'b0, 32'h0000_0F00, 1'b0, 1'b0, 1'b0);
        step(1);
        req_valid = 2'b10;
        step(1);
        rsp_ready = 2'b10;
        for (int i = 0; i < 3; i++) begin
            checkOutput("foreign_ready_valid",  {30'd0, rsp_valid}, 32'd1);
            checkOutput("foreign_ready_result", rsp_result, 32'h0000_0F00);
            checkOutput("foreign_ready_rdy",    {30'd0, req_ready}, 32'd0);
            step(1);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        step(1);
        rsp_ready = 2'b00;

        // Reset during EXEC of Xor abandons the operation and restores the pointer.
        applyStimulus(2'b01, 3'd6, 32'h0000_00F0, 32'h0000_000F, 3'd0, 32'd0, 32'd0);
        step(1);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        rst       = 1'b1;
        step(1);
        checkResetState("exec_reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checkOutput("exec_reset_no_rsp", {30'd0, rsp_valid}, 32'd0);
        end
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        #1;
        checkOutput("exec_reset_ptr", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;
        step(1);

`ifdef ALU_ARB_OPCHECK_EN
        // Opcode 7 is answered one cycle after accept with an error response.
        applyStimulus(2'b10, 3'd0, 32'd0, 32'd0, 3'd7, 32'd123, 32'd456);
        pushExpected(1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
        step(1);
        req_valid = 2'b00;
        checkOutput("op7_rsp_valid", {30'd0, rsp_valid}, 32'd2);
        checkOutput("op7_rsp_err",   {31'd0, rsp_err}, 32'd1);
        rsp_ready = 2'b10;
        step(1);
        rsp_ready = 2'b00;
        step(1);
`endif

        checkOutput("scoreboard_drained", sb.size(), 32'd0);
        checkOutput("alu_never_op7", {31'd0, saw_op7}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer that shares the single combinational `ALU` (3-bit opcode, two 32-bit operands, `zero`/`negative` flags) between two independent requesters, such as the main execute path and a secondary address/compare unit. It arbitrates round-robin, latches the winning operation, drives the ALU for exactly one cycle, and returns the registered result and flags over a valid/ready handshake. One operation is in flight at a time.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must match the ALU.
- `NREQ`, 2, number of requesters; fixed at 2.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input [1:0]: per-requester request valid.
- `req_ready` output [1:0]: per-requester request accepted this cycle.
- `req_op0`, `req_op1` input [2:0]: opcode, with ALU encoding 0 Add, 1 Sub, 2 And, 3 Or, 4 Slt, 5 Sltu, 6 Xor.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` input [WIDTH-1:0]: operands.
- `rsp_valid` output [1:0]: response valid, at most one bit high.
- `rsp_ready` input [1:0]: per-requester response consumed.
- `rsp_result` output [WIDTH-1:0]: registered ALU result.
- `rsp_zero`, `rsp_negative` output 1: registered ALU flags.
- `rsp_err` output 1: illegal opcode flag. Only exists under `ALU_ARB_OPCHECK_EN`.
- `alu_opcode` output [2:0], `alu_in1`/`alu_in2` output [WIDTH-1:0]: drive to the ALU.
- `alu_result` input [WIDTH-1:0], `alu_zero`/`alu_negative` input 1: from the ALU.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `req_ready[g]` = 1 only for the granted requester `g`, combinationally from `req_valid` and the priority pointer.
  - On `req_valid[g] & req_ready[g]`: latch requester id, opcode and operands, then go to EXEC.
- EXEC (one cycle):
  - `alu_opcode`/`alu_in1`/`alu_in2` come from the latched registers.
  - At the clock edge, capture `alu_result`, `alu_zero` and `alu_negative` into the response registers, then go to RESP.
- RESP:
  - `rsp_valid[id]` = 1. Result and flags are held stable.
  - On `rsp_ready[id]`: go to IDLE. The priority pointer moves to the other requester.
- Arbitration:
  - Only one requester valid: grant it.
  - Both valid: grant the requester the pointer favours. The pointer favours requester 0 after reset.
- Outside EXEC, the ALU inputs stay at their latched values. `alu_opcode` is 0 after reset, so ALU outputs never float.
- `rsp_ready` for the non-owning requester is ignored.
- `req_valid` deasserting after acceptance has no effect on the operation in flight.

## Timing
- Reset values:
  - State IDLE, pointer 0.
  - `rsp_valid` = 0, `req_ready` = 0 during the reset cycle.
  - `rsp_result` = 0, `rsp_zero` = 0, `rsp_negative` = 0, `rsp_err` = 0.
  - `alu_opcode` = 0, `alu_in1` = 0, `alu_in2` = 0.
- Cycle sequence:
  - Accept at edge N.
  - EXEC during cycle N+1.
  - `rsp_valid` high from cycle N+2.
  - Back-to-back throughput is one operation per 3 cycles when `rsp_ready` is held high.
- `rsp_valid` stays high until the handshake. No new request is accepted while in EXEC or RESP.
- `rst` asserted in any state: at the next edge the operation in flight is abandoned, all outputs return to reset values, and no response is issued.

## Configuration
- `ALU_ARB_OPCHECK_EN` defined:
  - Opcode 7 is accepted normally but skips EXEC. The FSM goes IDLE to RESP.
  - Response is `rsp_result` = 0, `rsp_zero` = 1, `rsp_negative` = 0, `rsp_err` = 1. Latency is 1 cycle.
  - The ALU is not driven with opcode 7.
  - `rsp_err` = 0 for legal opcodes.
- `ALU_ARB_OPCHECK_EN` undefined:
  - The `rsp_err` port and the check are absent.
  - Opcode 7 goes through EXEC like any other opcode. The result is whatever the ALU returns.

## Test plan
- Requester 0: Add, a=5, b=7. Expect `rsp_valid` = 2'b01 two cycles after accept, result 12, zero 0, negative 0.
- Requester 1: Sub, a=3, b=3, with `rsp_ready` held low for 4 cycles. Expect result 0, zero 1, held stable for all 4 cycles, released on ready.
- Both requesters valid continuously after reset: Slt (0xFFFFFFFF, 1) on 0 and Sltu (0xFFFFFFFF, 1) on 1. Expect grant order 0,1,0,1. Results are 1 for requester 0 and 0 for requester 1.
- Assert `rst` during EXEC of Xor (0xF0, 0x0F). Expect no `rsp_valid`, all outputs at reset values, and the pointer back to 0.
- With `ALU_ARB_OPCHECK_EN`: opcode 7 on requester 1. Expect `rsp_valid` = 2'b10 one cycle after accept, `rsp_err` 1, result 0, and `alu_opcode` never equal to 7.
- Response handshake: `rsp_ready[1]` asserted while requester 0 owns the response. Expect no state change.
